// File: rtl/spi_pkg.sv
// Shared SPI receive definitions: mode encodings, receiver states, synchronizer depth.
// Constant-foldable helpers only; no logic lives here.
package spi_pkg;

    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE1 = 2'd1,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } spi_mode_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_ARMED = 2'd1,
        RX_SHIFT = 2'd2
    } rx_state_e;

    localparam int SYNC_DEPTH = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with occupancy count; head word is read combinationally, zero when empty.
// A push while full is dropped (drop_o) unless a pop frees the slot in the same cycle.
module sync_fifo
    import spi_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      push_dat_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      head_dat_o,
    output logic                  head_vld_o,
    output logic                  drop_o,
    output logic [clog2(DEPTH):0] level_o
);

    localparam int PTR_W = clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             full;
    logic             pop_eff;
    logic             push_eff;

    assign full     = (count_q == FULL_CNT);
    assign pop_eff  = pop_i && (count_q != '0);
    assign push_eff = push_i && (!full || pop_eff);
    assign drop_o   = push_i && full && !pop_eff;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_eff) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_eff)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_eff && !pop_eff) begin
                count_q <= count_q + (PTR_W + 1)'(1);
            end else if (pop_eff && !push_eff) begin
                count_q <= count_q - (PTR_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_eff) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_vld_o = (count_q != '0);
    assign head_dat_o = head_vld_o ? mem_q[rd_ptr_q] : '0;
    assign level_o    = count_q;

endmodule

// File: rtl/spi_rx_fifo_slave.sv
// SPI slave receiver (any CPOL/CPHA) feeding a word FIFO tagged with start-of-frame.
// Word visible on m_valid ~4 CLOCK_50 cycles after its last sample edge; words arriving while full are dropped and flagged.
module spi_rx_fifo_slave
    import spi_pkg::*;
#(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0
) (
    input  logic                          CLOCK_50,
    input  logic                          RESET_N,
    input  logic                          SCK,
    input  logic                          MOSI,
    input  logic                          SSEL,
    output logic [WORD_W-1:0]             m_data,
    output logic                          m_sof,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          frame_end,
    output logic                          overflow,
    input  logic                          clr_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int              CNT_W       = clog2(WORD_W);
    localparam logic [1:0]      MODE_BITS   = 2'((CPOL % 2) * 2 + (CPHA % 2));
    localparam logic            SAMPLE_RISE = (MODE_BITS == MODE0) || (MODE_BITS == MODE3);
    localparam logic            SCK_IDLE    = (CPOL % 2) != 0;
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WORD_W - 1);

    logic [SYNC_DEPTH:0]   sck_q;
    logic [SYNC_DEPTH:0]   ssel_q;
    logic [SYNC_DEPTH-1:0] mosi_q;
    logic [SYNC_DEPTH-1:0] warm_q;

    logic sck_s, sck_prev, ssel_s, ssel_prev, mosi_s;
    logic sample_edge, ssel_rise;

    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WORD_W-2:0] shift_q;
    logic             sof_pend_q;
    logic             seen_hi_q;
    logic             push_vld_q;
    logic [WORD_W:0]  push_dat_q;
    logic             frame_end_q;
    logic             overflow_q;

    logic [WORD_W:0]  head_dat;
    logic             fifo_drop;

    // Reset values mimic an idle bus so the first real samples never look like an edge.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            sck_q  <= {(SYNC_DEPTH + 1){SCK_IDLE}};
            ssel_q <= '1;
            mosi_q <= '0;
            warm_q <= '0;
        end else begin
            sck_q  <= {sck_q[SYNC_DEPTH-1:0], SCK};
            ssel_q <= {ssel_q[SYNC_DEPTH-1:0], SSEL};
            mosi_q <= {mosi_q[SYNC_DEPTH-2:0], MOSI};
            warm_q <= {warm_q[SYNC_DEPTH-2:0], 1'b1};
        end
    end

    assign sck_s       = sck_q[SYNC_DEPTH-1];
    assign sck_prev    = sck_q[SYNC_DEPTH];
    assign ssel_s      = ssel_q[SYNC_DEPTH-1];
    assign ssel_prev   = ssel_q[SYNC_DEPTH];
    assign mosi_s      = mosi_q[SYNC_DEPTH-1];
    assign sample_edge = (sck_s != sck_prev) && (sck_s == SAMPLE_RISE);
    assign ssel_rise   = ssel_s && !ssel_prev;

    // seen_hi_q only trusts SSEL once the synchronizer holds genuine post-reset samples,
    // so a frame already running when reset lifts is skipped entirely.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            sof_pend_q  <= 1'b0;
            seen_hi_q   <= 1'b0;
            push_vld_q  <= 1'b0;
            push_dat_q  <= '0;
            frame_end_q <= 1'b0;
        end else begin
            push_vld_q  <= 1'b0;
            frame_end_q <= ssel_rise;
            seen_hi_q   <= seen_hi_q || (warm_q[SYNC_DEPTH-1] && ssel_s);
            if (ssel_s) begin
                state_q <= RX_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    RX_IDLE: begin
                        if (seen_hi_q) begin
                            state_q    <= RX_ARMED;
                            sof_pend_q <= 1'b1;
                        end
                    end
                    RX_ARMED, RX_SHIFT: begin
                        if (sample_edge) begin
                            if (cnt_q == LAST_BIT) begin
                                push_vld_q <= 1'b1;
                                push_dat_q <= {sof_pend_q, shift_q, mosi_s};
                                sof_pend_q <= 1'b0;
                                cnt_q      <= '0;
                                state_q    <= RX_ARMED;
                            end else begin
                                shift_q <= {shift_q[WORD_W-3:0], mosi_s};
                                cnt_q   <= cnt_q + CNT_W'(1);
                                state_q <= RX_SHIFT;
                            end
                        end
                    end
                    default: state_q <= RX_IDLE;
                endcase
            end
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (CLOCK_50),
        .rst_n_i    (RESET_N),
        .push_i     (push_vld_q),
        .push_dat_i (push_dat_q),
        .pop_i      (m_ready),
        .head_dat_o (head_dat),
        .head_vld_o (m_valid),
        .drop_o     (fifo_drop),
        .level_o    (level)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            overflow_q <= 1'b0;
        end else if (fifo_drop) begin
            overflow_q <= 1'b1;
        end else if (clr_ovf) begin
            overflow_q <= 1'b0;
        end
    end

    assign m_sof     = head_dat[WORD_W];
    assign m_data    = head_dat[WORD_W-1:0];
    assign frame_end = frame_end_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_spi_rx_fifo_slave.sv
// Bench for spi_rx_fifo_slave: five instances cover depth-16 mode 0, depth-4 overflow, and modes 1..3.
`timescale 1ns/1ps
module tb_spi_rx_fifo_slave;

    localparam time HALF = 1000;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_n;
    logic mosi;
    logic sck_w   [5];
    logic ssel_w  [5];
    logic ready_w [5];
    logic clr_w   [5];
    logic [7:0] data_w [5];
    logic sof_w   [5];
    logic valid_w [5];
    logic fe_w    [5];
    logic ovf_w   [5];
    logic [4:0] lvl0, lvl2, lvl3, lvl4;
    logic [2:0] lvl1;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q [$];
    time  sample_t = 0;
    time  vld_t0   = 0;
    logic vld_prev0 = 1'b0;
    int   fe_cnt0  = 0;

    spi_rx_fifo_slave #(.WORD_W(8), .FIFO_DEPTH(16), .CPOL(0), .CPHA(0)) u_m0 (
        .CLOCK_50(clk), .RESET_N(rst_n), .SCK(sck_w[0]), .MOSI(mosi), .SSEL(ssel_w[0]),
        .m_data(data_w[0]), .m_sof(sof_w[0]), .m_valid(valid_w[0]), .m_ready(ready_w[0]),
        .frame_end(fe_w[0]), .overflow(ovf_w[0]), .clr_ovf(clr_w[0]), .level(lvl0));

    spi_rx_fifo_slave #(.WORD_W(8), .FIFO_DEPTH(4), .CPOL(0), .CPHA(0)) u_d4 (
        .CLOCK_50(clk), .RESET_N(rst_n), .SCK(sck_w[1]), .MOSI(mosi), .SSEL(ssel_w[1]),
        .m_data(data_w[1]), .m_sof(sof_w[1]), .m_valid(valid_w[1]), .m_ready(ready_w[1]),
        .frame_end(fe_w[1]), .overflow(ovf_w[1]), .clr_ovf(clr_w[1]), .level(lvl1));

    spi_rx_fifo_slave #(.WORD_W(8), .FIFO_DEPTH(16), .CPOL(0), .CPHA(1)) u_m1 (
        .CLOCK_50(clk), .RESET_N(rst_n), .SCK(sck_w[2]), .MOSI(mosi), .SSEL(ssel_w[2]),
        .m_data(data_w[2]), .m_sof(sof_w[2]), .m_valid(valid_w[2]), .m_ready(ready_w[2]),
        .frame_end(fe_w[2]), .overflow(ovf_w[2]), .clr_ovf(clr_w[2]), .level(lvl2));

    spi_rx_fifo_slave #(.WORD_W(8), .FIFO_DEPTH(16), .CPOL(1), .CPHA(0)) u_m2 (
        .CLOCK_50(clk), .RESET_N(rst_n), .SCK(sck_w[3]), .MOSI(mosi), .SSEL(ssel_w[3]),
        .m_data(data_w[3]), .m_sof(sof_w[3]), .m_valid(valid_w[3]), .m_ready(ready_w[3]),
        .frame_end(fe_w[3]), .overflow(ovf_w[3]), .clr_ovf(clr_w[3]), .level(lvl3));

    spi_rx_fifo_slave #(.WORD_W(8), .FIFO_DEPTH(16), .CPOL(1), .CPHA(1)) u_m3 (
        .CLOCK_50(clk), .RESET_N(rst_n), .SCK(sck_w[4]), .MOSI(mosi), .SSEL(ssel_w[4]),
        .m_data(data_w[4]), .m_sof(sof_w[4]), .m_valid(valid_w[4]), .m_ready(ready_w[4]),
        .frame_end(fe_w[4]), .overflow(ovf_w[4]), .clr_ovf(clr_w[4]), .level(lvl4));

    always @(posedge clk) if (fe_w[0]) fe_cnt0 <= fe_cnt0 + 1;

    always @(negedge clk) begin
        if (valid_w[0] && !vld_prev0) vld_t0 = $time;
        vld_prev0 = valid_w[0];
    end

    function automatic logic cpol_of(input int idx);
        return (idx == 3) || (idx == 4);
    endfunction

    function automatic logic cpha_of(input int idx);
        return (idx == 2) || (idx == 4);
    endfunction

    task automatic start_frame(input int idx);
        ssel_w[idx] = 1'b0;
        #(HALF);
    endtask

    task automatic end_frame(input int idx);
        #(HALF);
        ssel_w[idx] = 1'b1;
        #(2 * HALF);
    endtask

    // MSB-first bit-bang of the top nbits of val in the instance's SPI mode.
    task automatic send_bits(input int idx, input logic [7:0] val, input int nbits);
        logic cpol, cpha;
        cpol = cpol_of(idx);
        cpha = cpha_of(idx);
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cpha) begin
                mosi = val[i];
                #(HALF);
                sck_w[idx] = ~cpol;
                sample_t = $time;
                #(HALF);
                sck_w[idx] = cpol;
            end else begin
                sck_w[idx] = ~cpol;
                mosi = val[i];
                #(HALF);
                sck_w[idx] = cpol;
                sample_t = $time;
                #(HALF);
            end
        end
    endtask

    task automatic pop_word(input int idx, output logic [8:0] got, output bit ok);
        ok  = 1'b0;
        got = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (valid_w[idx]) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            got = {sof_w[idx], data_w[idx]};
            ready_w[idx] = 1'b1;
            @(posedge clk);
            #1;
            ready_w[idx] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (lvl0 !== 5'd0)      begin errors++; $display("FAIL reset_level: got %0d expected 0", lvl0); end
        checks++; if (valid_w[0] !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_w[0]); end
        checks++; if (sof_w[0] !== 1'b0)   begin errors++; $display("FAIL reset_sof: got %b expected 0", sof_w[0]); end
        checks++; if (data_w[0] !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_w[0]); end
        checks++; if (ovf_w[0] !== 1'b0)   begin errors++; $display("FAIL reset_overflow: got %b expected 0", ovf_w[0]); end
        checks++; if (fe_w[0] !== 1'b0)    begin errors++; $display("FAIL reset_frame_end: got %b expected 0", fe_w[0]); end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_latency();
        logic [8:0] got, exp;
        bit ok;
        time lat;
        start_frame(0);
        exp_q.push_back({1'b1, 8'h96});
        send_bits(0, 8'h96, 8);
        lat = vld_t0 - sample_t;
        end_frame(0);
        checks++;
        if (vld_t0 == 0 || lat > 110) begin
            errors++; $display("FAIL latency: got %0t from last sample edge to observed m_valid, required <= 110ns", lat);
        end
        pop_word(0, got, ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok || got !== exp) begin errors++; $display("FAIL latency_pop: got ok=%0b sof_data=%h expected %h", ok, got, exp); end
    endtask

    task automatic test_basic();
        logic [8:0] got, exp;
        bit ok;
        int fe_before;
        logic [7:0] bytes [3];
        bytes = '{8'hAA, 8'h55, 8'h00};
        fe_before = fe_cnt0;
        start_frame(0);
        for (int b = 0; b < 3; b++) begin
            exp_q.push_back({(b == 0), bytes[b]});
            send_bits(0, bytes[b], 8);
        end
        end_frame(0);
        checks++; if (lvl0 !== 5'd3) begin errors++; $display("FAIL basic_level: got %0d expected 3", lvl0); end
        checks++;
        if (fe_cnt0 - fe_before != 1) begin errors++; $display("FAIL basic_frame_end: got %0d pulses expected 1", fe_cnt0 - fe_before); end
        for (int k = 0; k < 3; k++) begin
            pop_word(0, got, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || got !== exp) begin errors++; $display("FAIL basic_pop%0d: got ok=%0b sof_data=%h expected %h", k, ok, got, exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] got, exp;
        bit ok;
        logic [7:0] bytes [6];
        bytes = '{8'hAA, 8'h55, 8'h00, 8'h00, 8'h55, 8'hAA};
        for (int f = 0; f < 2; f++) begin
            start_frame(0);
            for (int b = 0; b < 3; b++) begin
                exp_q.push_back({(b == 0), bytes[f * 3 + b]});
                send_bits(0, bytes[f * 3 + b], 8);
            end
            end_frame(0);
        end
        checks++; if (lvl0 !== 5'd6) begin errors++; $display("FAIL b2b_level: got %0d expected 6", lvl0); end
        for (int k = 0; k < 6; k++) begin
            pop_word(0, got, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || got !== exp) begin errors++; $display("FAIL b2b_pop%0d: got ok=%0b sof_data=%h expected %h", k, ok, got, exp); end
        end
    endtask

    task automatic test_overflow();
        logic [8:0] got, exp;
        bit ok;
        start_frame(1);
        for (int b = 0; b < 5; b++) begin
            if (b < 4) exp_q.push_back({(b == 0), 8'(8'h11 * (b + 1))});
            send_bits(1, 8'(8'h11 * (b + 1)), 8);
        end
        end_frame(1);
        checks++; if (lvl1 !== 3'd4)    begin errors++; $display("FAIL ovf_level: got %0d expected 4", lvl1); end
        checks++; if (ovf_w[1] !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", ovf_w[1]); end
        for (int k = 0; k < 4; k++) begin
            pop_word(1, got, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || got !== exp) begin errors++; $display("FAIL ovf_pop%0d: got ok=%0b sof_data=%h expected %h", k, ok, got, exp); end
        end
        @(negedge clk);
        checks++; if (valid_w[1] !== 1'b0) begin errors++; $display("FAIL ovf_fifth_absent: got valid=%b expected 0", valid_w[1]); end
        checks++; if (ovf_w[1] !== 1'b1)   begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf_w[1]); end
        clr_w[1] = 1'b1;
        @(posedge clk);
        #1;
        clr_w[1] = 1'b0;
        @(negedge clk);
        checks++; if (ovf_w[1] !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ovf_w[1]); end
    endtask

    task automatic test_abort();
        logic [8:0] got, exp;
        bit ok;
        start_frame(0);
        send_bits(0, 8'hA5, 5);
        end_frame(0);
        checks++; if (lvl0 !== 5'd0) begin errors++; $display("FAIL abort_no_push: got level %0d expected 0", lvl0); end
        start_frame(0);
        exp_q.push_back({1'b1, 8'hC3});
        send_bits(0, 8'hC3, 8);
        end_frame(0);
        pop_word(0, got, ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok || got !== exp) begin errors++; $display("FAIL abort_next_word: got ok=%0b sof_data=%h expected %h", ok, got, exp); end
    endtask

    task automatic test_modes();
        logic [8:0] got, exp;
        bit ok;
        for (int idx = 2; idx < 5; idx++) begin
            start_frame(idx);
            exp_q.push_back({1'b1, 8'h3C});
            send_bits(idx, 8'h3C, 8);
            end_frame(idx);
            pop_word(idx, got, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || got !== exp) begin errors++; $display("FAIL mode%0d_rx: got ok=%0b sof_data=%h expected %h", idx - 1, ok, got, exp); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [8:0] got, exp;
        bit ok;
        start_frame(0);
        fork
            begin
                send_bits(0, 8'h81, 8);
                send_bits(0, 8'h7E, 8);
            end
            begin
                #3000;
                @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        end_frame(0);
        checks++; if (lvl0 !== 5'd0)      begin errors++; $display("FAIL midreset_level: got %0d expected 0", lvl0); end
        checks++; if (valid_w[0] !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", valid_w[0]); end
        start_frame(0);
        exp_q.push_back({1'b1, 8'h5A});
        send_bits(0, 8'h5A, 8);
        end_frame(0);
        pop_word(0, got, ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok || got !== exp) begin errors++; $display("FAIL midreset_next_frame: got ok=%0b sof_data=%h expected %h", ok, got, exp); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "timeout");
    end

    initial begin
        mosi = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sck_w[i]   = cpol_of(i);
            ssel_w[i]  = 1'b1;
            ready_w[i] = 1'b0;
            clr_w[i]   = 1'b0;
        end
        test_reset();
        test_latency();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_abort();
        test_modes();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_rx_fifo_slave.md
SPI_RX_FIFO_SLAVE -- requirements
Module: spi_rx_fifo_slave

Interface
REQ-001 SHALL have parameter WORD_W, default 8: bits per received word (4..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: receive FIFO entries (power of 2, 2..256).
REQ-003 SHALL have parameter CPOL, default 0: SCK idle level.
REQ-004 SHALL have parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-005 SHALL have port CLOCK_50  input  1: sole clock; all state is on its rising edge.
REQ-006 SHALL have port RESET_N  input  1: reset, synchronous and active-low.
REQ-007 SHALL have ports SCK, MOSI, SSEL  input  1 each: asynchronous SPI pins; SSEL is active-low.
REQ-008 SHALL have port m_data  output  WORD_W: FIFO head word, MSB received first.
REQ-009 SHALL have port m_sof  output  1: head word is the first complete word of its frame.
REQ-010 SHALL have port m_valid  output  1: FIFO non-empty.
REQ-011 SHALL have port m_ready  input  1: consumer accepts head when m_valid and m_ready are both high.
REQ-012 SHALL have port frame_end  output  1: one-cycle pulse on each synchronized SSEL rising edge.
REQ-013 SHALL have port overflow  output  1: sticky, word dropped because FIFO full.
REQ-014 SHALL have port clr_ovf  input  1: clears overflow.
REQ-015 SHALL have port level  output  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Function
REQ-016 SHALL pass SCK, MOSI and SSEL through 2-flop synchronizers, then a third register for edge detection.
REQ-017 SHALL derive the sample edge from CPOL/CPHA: rising for modes 0 and 3, falling for modes 1 and 2.
REQ-018 SHALL shift MOSI into a WORD_W shift register MSB-first on each sample edge while synchronized SSEL is low.
REQ-019 SHALL, on the WORD_W-th sample edge, push {sof, word} into the FIFO and reset the bit counter to 0.
REQ-020 SHALL present a pushed word on m_valid no later than 5 CLOCK_50 cycles after the final sampling SCK edge at the pin.
REQ-021 SHALL set sof for the first word pushed after each SSEL falling edge and clear it for subsequent words.
REQ-022 SHALL discard the partial word and clear the bit counter when SSEL rises mid-word; no push occurs.
REQ-023 SHALL drop the word, keep FIFO contents, and set overflow when a push occurs while full and m_ready is low.
REQ-024 SHALL accept the push when full if a pop happens in the same cycle; level stays FIFO_DEPTH.
REQ-025 SHALL keep level unchanged on simultaneous push and pop when non-empty; pop on empty is ignored.
REQ-026 SHALL give a set of overflow priority over clr_ovf in the same cycle.
REQ-027 SHALL wrap read and write pointers modulo FIFO_DEPTH.
REQ-028 SHALL hold m_data and m_sof stable while m_valid is high and m_ready is low.
REQ-029 SHALL use receiver states IDLE (SSEL high), ARMED (SSEL low, counter 0), and SHIFT (counter > 0).
REQ-030 SHALL transition IDLE->ARMED on SSEL fall, ARMED->SHIFT on a sample edge, SHIFT->ARMED on word completion, and any state->IDLE on SSEL rise.

Reset
REQ-031 SHALL, while RESET_N is low at a clock edge, empty the FIFO and force level=0, m_valid=0, m_sof=0, overflow=0, frame_end=0, m_data=0, state=IDLE, and bit counter=0.
REQ-032 SHALL reset synchronizers to SSEL=1, SCK=CPOL and MOSI=0 so that no spurious edge follows reset.
REQ-033 SHALL, after reset, ignore SPI traffic until synchronized SSEL is seen high, so a frame in progress at reset is never received.

Structure
REQ-034 SHALL place SPI mode constants (MODE0..MODE3), sync depth (2) and a clog2 function in shared package spi_pkg.
REQ-035 SHALL implement the FIFO as one sub-module, sync_fifo, parameterized by width (WORD_W+1) and depth.

Verification
REQ-036 SHALL cover this case with mode 0, SCK half-period 1 us and CLOCK_50 at 50 MHz: frame AA,55,00 -> three pops AA/sof=1, 55/0, 00/0, and one frame_end.
REQ-037 SHALL cover this case: frame 00,55,AA sent back-to-back after REQ-036 with m_ready=0 -> level=6, then drain in order with sof on words 1 and 4.
REQ-038 SHALL cover this case with FIFO_DEPTH=4 and m_ready=0: 5 words sent -> level=4, overflow=1, and the fifth word absent; clr_ovf then clears overflow.
REQ-039 SHALL cover this case: SSEL raised after 5 bits of A5 -> no push, and the next frame's word C3 arrives with sof=1.
REQ-040 SHALL cover this case: modes 1, 2 and 3 each receiving 3C -> m_data=3C.
REQ-041 SHALL cover this case: RESET_N pulsed low for 1 cycle mid-frame -> remainder of the frame is ignored, and the next frame is received intact.
